i2s_playback_tx: RTL and testbench
==================================

I2S_PLAYBACK_TX -- requirements
Module: i2s_playback_tx

Interface
REQ-001 Parameter: LEFT_JUSTIFIED, default 0; 0 = I2S (MSB one bclk after pblrc edge), 1 = left-justified (MSB coincident with pblrc edge).
REQ-002 Port: mclk  input  1  master clock, 256x sample rate; sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: sample_l  input  16 (shortint, signed)  left-channel sample from the oscillator/overdrive stage.
REQ-005 Port: sample_r  input  16 (shortint, signed)  right-channel sample.
REQ-006 Port: mute  input  1  when sampled high at frame boundary, the next frame SHALL carry zeros on both channels.
REQ-007 Port: bclk  output  1  codec bit clock, mclk/4.
REQ-008 Port: pblrc  output  1  playback LR clock, mclk/256; low = left, high = right; the oscillator sources consume it as their sample-rate input.
REQ-009 Port: pbdat  output  1  serial playback data, MSB first.
REQ-010 Port: frame_start  output  1  one-mclk pulse marking the first cycle of each frame.

Function
REQ-011 An 8-bit frame counter cnt SHALL increment by 1 every mclk, wrapping 255 -> 0.
REQ-012 All outputs SHALL be registered and SHALL satisfy, every cycle: bclk == cnt[1]; pblrc == cnt[7]; frame_start == (cnt == 0).
REQ-013 Frame: 64 bclk periods; 32 bit slots per channel; slot index k = cnt[6:2]; channel = cnt[7].
REQ-014 On the edge where cnt goes 255 -> 0, shadow_l <= sample_l, shadow_r <= sample_r, mute_q <= mute; when mute is high, both shadows SHALL load 0 instead.
REQ-015 Both channels SHALL be captured on the same edge; sample inputs SHALL be ignored at all other cycles.
REQ-016 LEFT_JUSTIFIED = 0: pbdat = shadow_ch[16-k] for 1 <= k <= 16; otherwise 0.
REQ-017 LEFT_JUSTIFIED = 1: pbdat = shadow_ch[15-k] for 0 <= k <= 15; otherwise 0.
REQ-018 pbdat SHALL change only when cnt[1:0] == 0, i.e. on bclk falling edges; it SHALL be stable across each bclk rising edge.
REQ-019 Latency: a sample present at cnt == 255 SHALL begin serialising within the frame starting at the next cycle (left MSB at cnt 4 in I2S mode, cnt 0 in LJ mode); right MSB at cnt 132 or cnt 128.
REQ-020 Values 0x8000 and 0x7FFF SHALL serialise bit-exact, with no saturation or sign-extension into slots 17-31.
REQ-021 A change of mute mid-frame SHALL have no effect until the next 255 -> 0 boundary.

Reset
REQ-022 While rst is high: cnt = 0, shadow_l = shadow_r = 0, mute_q = 0, bclk = 0, pblrc = 0, pbdat = 0, frame_start = 0.
REQ-023 Assertion mid-frame SHALL force these values immediately, without waiting for an mclk edge.
REQ-024 On release, counting SHALL resume from cnt = 0 with frame_start high on the first cycle.
REQ-025 The first frame after reset SHALL transmit zeros; the first input capture SHALL occur at the first 255 -> 0 wrap.

Verification
REQ-026 Basic I2S (LEFT_JUSTIFIED = 0): sample_l = 0x8001, sample_r = 0x7FFE held; decode frame 2 on bclk rising edges -> left slots 1-16 = 1000000000000001, right slots 1-16 = 0111111111111110, all other slots 0.
REQ-027 LJ mode (LEFT_JUSTIFIED = 1): sample_l = 0xA5A5 -> left slots 0-15 = 1010010110100101, slots 16-31 = 0.
REQ-028 Capture window:
- stimulus: sample_l changes 0x1234 -> 0x4321 at cnt = 100, then back to 0x1234 at cnt = 254.
- required response: the next frame carries 0x1234.
- required response: a change to 0x4321 at cnt = 254 held through 255 yields 0x4321 in the next frame.
REQ-029 Mute: mute pulsed high at cnt = 60 only -> no effect; mute high at cnt = 255 with sample_l = 0x7FFF -> the next frame is all-zero pbdat; the frame after resumes 0x7FFF once mute is low.
REQ-030 Clock ratios: over 1024 mclk cycles -> exactly 4 pblrc periods, 256 bclk periods, and 4 frame_start pulses, each pulse 1 cycle wide at pblrc falling edges.
REQ-031 Reset mid-frame: rst asserted asynchronously at cnt = 137, between edges -> all outputs 0 before the next edge; after release the first frame is zero and the second carries the live samples.

Source files
------------

// File: rtl/i2s_playback_tx.sv
// rtl/i2s_playback_tx.sv - I2S / left-justified stereo playback serializer, 16-bit samples in 32-bit slots.
module i2s_playback_tx #(
    parameter bit LEFT_JUSTIFIED = 1'b0
) (
    input  logic               mclk,
    input  logic               rst,
    input  logic signed [15:0] sample_l,
    input  logic signed [15:0] sample_r,
    input  logic               mute,
    output logic               bclk,
    output logic               pblrc,
    output logic               pbdat,
    output logic               frame_start
);

    logic [7:0]  cnt_q, cnt_d;
    logic        run_q;
    logic [15:0] shadow_l_q, shadow_l_d;
    logic [15:0] shadow_r_q, shadow_r_d;
    logic        mute_q, mute_d;
    logic        bclk_q, pblrc_q, pbdat_q, frame_start_q;
    logic        pbdat_d;
    logic [4:0]  slot;
    logic [3:0]  idx;
    logic        in_range;
    logic [15:0] shadow_ch;

    // Outputs are registered from next-state values so they track cnt in the same cycle.
    always_comb begin
        cnt_d      = run_q ? cnt_q + 8'd1 : 8'd0;
        shadow_l_d = shadow_l_q;
        shadow_r_d = shadow_r_q;
        mute_d     = mute_q;
        if (run_q && (cnt_q == 8'hFF)) begin
            mute_d     = mute;
            shadow_l_d = mute ? 16'h0000 : sample_l;
            shadow_r_d = mute ? 16'h0000 : sample_r;
        end

        slot      = cnt_d[6:2];
        shadow_ch = cnt_d[7] ? shadow_r_d : shadow_l_d;
        if (LEFT_JUSTIFIED) begin
            in_range = !slot[4];
            idx      = ~slot[3:0];
        end else begin
            in_range = (slot != 5'd0) && (slot <= 5'd16);
            idx      = ~(slot[3:0] - 4'd1);
        end
        pbdat_d = in_range && !mute_d && shadow_ch[idx];
    end

    // run_q holds cnt at 0 for the first cycle after release so frame_start marks it.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            run_q         <= 1'b0;
            cnt_q         <= 8'd0;
            shadow_l_q    <= 16'h0000;
            shadow_r_q    <= 16'h0000;
            mute_q        <= 1'b0;
            bclk_q        <= 1'b0;
            pblrc_q       <= 1'b0;
            pbdat_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            cnt_q         <= cnt_d;
            shadow_l_q    <= shadow_l_d;
            shadow_r_q    <= shadow_r_d;
            mute_q        <= mute_d;
            bclk_q        <= cnt_d[1];
            pblrc_q       <= cnt_d[7];
            pbdat_q       <= pbdat_d;
            frame_start_q <= (cnt_d == 8'd0);
        end
    end

    assign bclk        = bclk_q;
    assign pblrc       = pblrc_q;
    assign pbdat       = pbdat_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_i2s_playback_tx.sv
// tb/tb_i2s_playback_tx.sv - directed bench for i2s_playback_tx in I2S and left-justified modes.
module tb_i2s_playback_tx;

    logic        mclk;
    logic        rst;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        mute;
    logic        bclk0, pblrc0, pbdat0, fs0;
    logic        bclk1, pblrc1, pbdat1, fs1;

    int checks = 0;
    int errors = 0;

    logic [7:0] tb_cnt;
    logic       tb_run;

    i2s_playback_tx #(.LEFT_JUSTIFIED(1'b0)) dut_i2s (
        .mclk(mclk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r), .mute(mute),
        .bclk(bclk0), .pblrc(pblrc0), .pbdat(pbdat0), .frame_start(fs0)
    );

    i2s_playback_tx #(.LEFT_JUSTIFIED(1'b1)) dut_lj (
        .mclk(mclk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r), .mute(mute),
        .bclk(bclk1), .pblrc(pblrc1), .pbdat(pbdat1), .frame_start(fs1)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // Frame position as defined for the design: 0 on the first cycle after release, then +1 per mclk.
    always @(posedge mclk or posedge rst) begin
        if (rst) begin
            tb_run <= 1'b0;
            tb_cnt <= 8'd0;
        end else begin
            tb_run <= 1'b1;
            tb_cnt <= tb_run ? tb_cnt + 8'd1 : 8'd0;
        end
    end

    task automatic goto(input int v);
        int guard = 0;
        do begin
            @(negedge mclk);
            guard++;
        end while ((int'(tb_cnt) != v) && (guard < 600));
        if (int'(tb_cnt) != v) begin
            checks++;
            errors++;
            $display("FAIL goto_timeout: got cnt %0d expected %0d", tb_cnt, v);
        end
    endtask

    // Samples one frame starting at the current negedge (cnt 0), reading pbdat mid bclk-high.
    task automatic capture(input int mute_at, output logic [31:0] l0, output logic [31:0] r0,
                           output logic [31:0] l1, output logic [31:0] r1);
        l0 = '0; r0 = '0; l1 = '0; r1 = '0;
        for (int i = 0; i < 256; i++) begin
            if (i == mute_at) mute = 1'b1;
            if (i == mute_at + 1) mute = 1'b0;
            if (tb_cnt[1:0] == 2'd2) begin
                if (tb_cnt[7]) begin
                    r0[31 - tb_cnt[6:2]] = pbdat0;
                    r1[31 - tb_cnt[6:2]] = pbdat1;
                end else begin
                    l0[31 - tb_cnt[6:2]] = pbdat0;
                    l1[31 - tb_cnt[6:2]] = pbdat1;
                end
            end
            if (i < 255) @(negedge mclk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] g[4];
        rst = 1'b1; mute = 1'b0; sample_l = 16'h8001; sample_r = 16'h7FFE;
        @(negedge mclk);
        checks++;
        if ({bclk0, pblrc0, pbdat0, fs0, bclk1, pblrc1, pbdat1, fs1} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {bclk0, pblrc0, pbdat0, fs0, bclk1, pblrc1, pbdat1, fs1});
        end
        rst = 1'b0;
        @(negedge mclk);
        checks++;
        if ({fs0, fs1, pblrc0, bclk0} !== 4'b1100) begin
            errors++;
            $display("FAIL release_first_cycle: got %b expected 1100", {fs0, fs1, pblrc0, bclk0});
        end
        capture(-1, g[0], g[1], g[2], g[3]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (g[i] !== 32'h0) begin
                errors++;
                $display("FAIL first_frame_zero[%0d]: got %h expected 00000000", i, g[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] g[4];
        logic [31:0] e[4];
        e = '{{1'b0, 16'h8001, 15'h0}, {1'b0, 16'h7FFE, 15'h0}, {16'h8001, 16'h0}, {16'h7FFE, 16'h0}};
        goto(0);
        capture(-1, g[0], g[1], g[2], g[3]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (g[i] !== e[i]) begin
                errors++;
                $display("FAIL basic_frame2[%0d]: got %h expected %h", i, g[i], e[i]);
            end
        end
    endtask

    task automatic test_left_justified();
        logic [31:0] g[4];
        logic [31:0] e[4];
        e = '{{1'b0, 16'hA5A5, 15'h0}, {1'b0, 16'h8000, 15'h0}, {16'hA5A5, 16'h0}, {16'h8000, 16'h0}};
        sample_l = 16'hA5A5; sample_r = 16'h8000;
        goto(0);
        capture(-1, g[0], g[1], g[2], g[3]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (g[i] !== e[i]) begin
                errors++;
                $display("FAIL lj_a5a5[%0d]: got %h expected %h", i, g[i], e[i]);
            end
        end
    endtask

    task automatic test_capture_window();
        logic [31:0] g[4];
        sample_l = 16'h1234;
        goto(100); sample_l = 16'h4321;
        goto(254); sample_l = 16'h1234;
        goto(0);
        capture(-1, g[0], g[1], g[2], g[3]);
        checks++;
        if ({g[0], g[2]} !== {1'b0, 16'h1234, 15'h0, 16'h1234, 16'h0}) begin
            errors++;
            $display("FAIL window_restore: got %h/%h expected %h/%h", g[0], g[2],
                     {1'b0, 16'h1234, 15'h0}, {16'h1234, 16'h0});
        end
        goto(254); sample_l = 16'h4321;
        goto(0);
        capture(-1, g[0], g[1], g[2], g[3]);
        checks++;
        if ({g[0], g[2]} !== {1'b0, 16'h4321, 15'h0, 16'h4321, 16'h0}) begin
            errors++;
            $display("FAIL window_late_change: got %h/%h expected %h/%h", g[0], g[2],
                     {1'b0, 16'h4321, 15'h0}, {16'h4321, 16'h0});
        end
    endtask

    task automatic test_mute();
        logic [31:0] g[4];
        sample_l = 16'h7FFF; sample_r = 16'h7FFE;
        goto(0);
        capture(60, g[0], g[1], g[2], g[3]);
        checks++;
        if ({g[0], g[3]} !== {1'b0, 16'h7FFF, 15'h0, 16'h7FFE, 16'h0}) begin
            errors++;
            $display("FAIL mute_midframe_same: got %h/%h expected %h/%h", g[0], g[3],
                     {1'b0, 16'h7FFF, 15'h0}, {16'h7FFE, 16'h0});
        end
        goto(0);
        capture(-1, g[0], g[1], g[2], g[3]);
        checks++;
        if ({g[0], g[2]} !== {1'b0, 16'h7FFF, 15'h0, 16'h7FFF, 16'h0}) begin
            errors++;
            $display("FAIL mute_midframe_next: got %h/%h expected %h/%h", g[0], g[2],
                     {1'b0, 16'h7FFF, 15'h0}, {16'h7FFF, 16'h0});
        end
        mute = 1'b1;
        goto(0);
        mute = 1'b0;
        capture(-1, g[0], g[1], g[2], g[3]);
        checks++;
        if ({g[0], g[1], g[2], g[3]} !== 128'h0) begin
            errors++;
            $display("FAIL mute_frame_zero: got %h %h %h %h expected all zero", g[0], g[1], g[2], g[3]);
        end
        goto(0);
        capture(-1, g[0], g[1], g[2], g[3]);
        checks++;
        if ({g[0], g[2]} !== {1'b0, 16'h7FFF, 15'h0, 16'h7FFF, 16'h0}) begin
            errors++;
            $display("FAIL mute_resume: got %h/%h expected %h/%h", g[0], g[2],
                     {1'b0, 16'h7FFF, 15'h0}, {16'h7FFF, 16'h0});
        end
    endtask

    task automatic test_clock_ratios();
        int lr_rise = 0, bclk_rise = 0, fs_count = 0, fs_bad = 0, rel_bad = 0, stab_bad = 0;
        logic p_lr, p_bclk, p_fs, p_d0, p_d1;
        @(negedge mclk);
        p_lr = pblrc0; p_bclk = bclk0; p_fs = fs0; p_d0 = pbdat0; p_d1 = pbdat1;
        for (int i = 0; i < 1024; i++) begin
            @(negedge mclk);
            if (pblrc0 && !p_lr) lr_rise++;
            if (bclk0 && !p_bclk) bclk_rise++;
            if (fs0) begin
                fs_count++;
                if (p_fs || !p_lr || pblrc0) fs_bad++;
            end
            if ({bclk0, pblrc0, fs0} !== {tb_cnt[1], tb_cnt[7], tb_cnt == 8'd0}) rel_bad++;
            if ({bclk1, pblrc1, fs1} !== {bclk0, pblrc0, fs0}) rel_bad++;
            if ((tb_cnt[1:0] != 2'd0) && ({pbdat0, pbdat1} !== {p_d0, p_d1})) stab_bad++;
            p_lr = pblrc0; p_bclk = bclk0; p_fs = fs0; p_d0 = pbdat0; p_d1 = pbdat1;
        end
        checks++;
        if (lr_rise != 4) begin errors++; $display("FAIL pblrc_periods: got %0d expected 4", lr_rise); end
        checks++;
        if (bclk_rise != 256) begin errors++; $display("FAIL bclk_periods: got %0d expected 256", bclk_rise); end
        checks++;
        if (fs_count != 4) begin errors++; $display("FAIL frame_start_pulses: got %0d expected 4", fs_count); end
        checks++;
        if (fs_bad != 0) begin errors++; $display("FAIL frame_start_shape: got %0d bad expected 0", fs_bad); end
        checks++;
        if (rel_bad != 0) begin errors++; $display("FAIL clock_relations: got %0d bad expected 0", rel_bad); end
        checks++;
        if (stab_bad != 0) begin errors++; $display("FAIL pbdat_stability: got %0d bad expected 0", stab_bad); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] g[4];
        sample_l = 16'h8001; sample_r = 16'h7FFE;
        goto(0);
        goto(137);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bclk0, pblrc0, pbdat0, fs0, bclk1, pblrc1, pbdat1, fs1} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b expected 00000000",
                     {bclk0, pblrc0, pbdat0, fs0, bclk1, pblrc1, pbdat1, fs1});
        end
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        @(negedge mclk);
        checks++;
        if ({fs0, fs1} !== 2'b11) begin
            errors++;
            $display("FAIL rerelease_frame_start: got %b expected 11", {fs0, fs1});
        end
        capture(-1, g[0], g[1], g[2], g[3]);
        checks++;
        if ({g[0], g[1], g[2], g[3]} !== 128'h0) begin
            errors++;
            $display("FAIL rerelease_zero_frame: got %h %h %h %h expected all zero", g[0], g[1], g[2], g[3]);
        end
        goto(0);
        capture(-1, g[0], g[1], g[2], g[3]);
        checks++;
        if ({g[0], g[1], g[2], g[3]} !== {1'b0, 16'h8001, 15'h0, 1'b0, 16'h7FFE, 15'h0,
                                         16'h8001, 16'h0, 16'h7FFE, 16'h0}) begin
            errors++;
            $display("FAIL rerelease_live_frame: got %h %h %h %h expected 40008000 3fff0000 80010000 7ffe0000",
                     g[0], g[1], g[2], g[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_left_justified();
        test_capture_window();
        test_mute();
        test_clock_ratios();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
